// File: rtl/i_prefetch_buffer.sv
// Next-line instruction prefetch buffer.
// Sits between the i-cache physical-memory port and the memory arbiter.
// Demand misses pass straight through. After every line delivered to the
// cache, the following 32-byte line is fetched into a one-entry buffer, so a
// later sequential miss is served without a memory round trip.
module i_prefetch_buffer #(
  parameter int PREFETCH_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic [31:0]  pmem_address,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         arb_read,
  output logic [31:0]  arb_address,
  input  logic [255:0] arb_rdata,
  input  logic         arb_resp
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BUF_RESP = 3'd1;
  localparam logic [2:0] S_DEMAND   = 3'd2;
  localparam logic [2:0] S_PREFETCH = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic LP_PF_EN = (PREFETCH_EN != 0);

  logic [2:0]   r_state;
  logic [2:0]   w_next_state;

  logic         r_buf_valid;
  logic [26:0]  r_buf_tag;
  logic [255:0] r_buf_data;
  logic         r_pf_pending;
  logic [26:0]  r_pf_addr;
  logic [26:0]  r_req_addr;

  logic         w_hit;
  logic         w_unused;

  // Byte offset within a line never matters; lines are fetched whole.
  assign w_unused = ^pmem_address[4:0];

  assign w_hit = r_buf_valid && (r_buf_tag == pmem_address[31:5]);

  // Next-state selection; a demand request always beats a pending prefetch.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (pmem_read) begin
          w_next_state = w_hit ? S_BUF_RESP : S_DEMAND;
        end else if (r_pf_pending) begin
          w_next_state = S_PREFETCH;
        end
      end
      S_BUF_RESP: w_next_state = S_DONE;
      S_DEMAND: begin
        if (arb_resp) begin
          w_next_state = S_DONE;
        end
      end
      S_PREFETCH: begin
        // The arbiter transaction always runs to completion; a waiting
        // request is re-evaluated against the new buffer contents in IDLE.
        if (arb_resp) begin
          w_next_state = S_IDLE;
        end
      end
      // DONE swallows the cache's trailing request cycle.
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset drops arb_read immediately because it decodes state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Buffer, prefetch bookkeeping and latched demand address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid  <= 1'b0;
      r_buf_tag    <= '0;
      r_buf_data   <= '0;
      r_pf_pending <= 1'b0;
      r_pf_addr    <= '0;
      r_req_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pmem_read && !w_hit) begin
            r_req_addr <= pmem_address[31:5];
          end
        end
        S_BUF_RESP: begin
          // The line now lives in the cache; keeping it would only duplicate it.
          r_buf_valid <= 1'b0;
          if (LP_PF_EN) begin
            // 27-bit line arithmetic wraps from the top line to line 0.
            r_pf_addr    <= r_buf_tag + 27'd1;
            r_pf_pending <= 1'b1;
          end
        end
        S_DEMAND: begin
          if (arb_resp && LP_PF_EN) begin
            r_pf_addr    <= r_req_addr + 27'd1;
            r_pf_pending <= 1'b1;
          end
        end
        S_PREFETCH: begin
          if (arb_resp) begin
            r_buf_data   <= arb_rdata;
            r_buf_tag    <= r_pf_addr;
            r_buf_valid  <= 1'b1;
            r_pf_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Demand data is a combinational pass-through so a miss adds no return cycle.
  assign pmem_resp  = (r_state == S_BUF_RESP) || ((r_state == S_DEMAND) && arb_resp);
  assign pmem_rdata = (r_state == S_DEMAND) ? arb_rdata : r_buf_data;

  assign arb_read    = (r_state == S_DEMAND) || (r_state == S_PREFETCH);
  assign arb_address = (r_state == S_DEMAND)   ? {r_req_addr, 5'b0} :
                       (r_state == S_PREFETCH) ? {r_pf_addr, 5'b0}  : 32'd0;

endmodule

// File: tb/tb_i_prefetch_buffer.sv
// Bench for i_prefetch_buffer: one instance with prefetch enabled and one
// configured as a pure pass-through. Expected lines and arbiter requests are
// queued as stimulus is issued and consumed when the DUT produces them.
module tb_i_prefetch_buffer;

  localparam int PERIOD = 10;

  typedef struct packed {
    logic [31:0] addr;
    logic        demand;
  } arb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(PERIOD / 2) clk = ~clk;

  // Prefetching instance
  logic         pmem_read    = 1'b0;
  logic [31:0]  pmem_address = 32'd0;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         arb_read;
  logic [31:0]  arb_address;
  logic [255:0] arb_rdata    = '0;
  logic         arb_resp     = 1'b0;

  // Pass-through instance
  logic         q_read       = 1'b0;
  logic [31:0]  q_addr       = 32'd0;
  logic [255:0] q_rdata;
  logic         q_resp;
  logic         q_arb_read;
  logic [31:0]  q_arb_addr;
  logic [255:0] q_arb_rdata  = '0;
  logic         q_arb_resp   = 1'b0;

  i_prefetch_buffer #(.PREFETCH_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_read(arb_read), .arb_address(arb_address),
    .arb_rdata(arb_rdata), .arb_resp(arb_resp)
  );

  i_prefetch_buffer #(.PREFETCH_EN(0)) u_dut_pt (
    .clk(clk), .rst(rst),
    .pmem_read(q_read), .pmem_address(q_addr),
    .pmem_rdata(q_rdata), .pmem_resp(q_resp),
    .arb_read(q_arb_read), .arb_address(q_arb_addr),
    .arb_rdata(q_arb_rdata), .arb_resp(q_arb_resp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] exp_resp[$];
  arb_exp_t     exp_arb[$];

  time t_resp      = 0;
  time t_arb_resp  = 0;
  time t_read_resp = 0;
  int  n_resp      = 0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {4{a, a ^ 32'hC3A5_5A3C}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cond(input string tag, input logic cond);
    n_tests++;
    assert (cond === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: condition observed %b, expected 1", tag, cond);
    end
  endtask

  task automatic push_resp(input logic [31:0] a);
    exp_resp.push_back(line_of({a[31:5], 5'b0}));
  endtask

  task automatic push_arb(input logic [31:0] a, input logic demand);
    arb_exp_t e;
    e.addr   = {a[31:5], 5'b0};
    e.demand = demand;
    exp_arb.push_back(e);
  endtask

  // Arbiter models: fixed latency, data derived from the line address.
  int lat1 = 5;
  int cnt1 = 0;
  int lat2 = 3;
  int cnt2 = 0;
  always @(posedge clk) begin
    #1;
    arb_resp   = 1'b0;
    q_arb_resp = 1'b0;
    if (rst || !arb_read) begin
      cnt1 = 0;
    end else begin
      cnt1++;
      if (cnt1 >= lat1) begin
        arb_resp  = 1'b1;
        arb_rdata = line_of(arb_address);
        cnt1      = 0;
      end
    end
    if (rst || !q_arb_read) begin
      cnt2 = 0;
    end else begin
      cnt2++;
      if (cnt2 >= lat2) begin
        q_arb_resp  = 1'b1;
        q_arb_rdata = line_of(q_arb_addr);
        cnt2        = 0;
      end
    end
  end

  // Monitor for the prefetching instance, sampled on the falling edge.
  logic         prev_resp  = 1'b0;
  logic         prev_arb   = 1'b0;
  logic [31:0]  prev_addr  = 32'd0;
  logic         cur_demand = 1'b0;
  arb_exp_t     mon_e;
  logic [255:0] mon_line;
  always @(negedge clk) begin
    if (rst) begin
      prev_resp = 1'b0;
      prev_arb  = 1'b0;
    end else begin
      if (pmem_resp) begin
        n_resp++;
        check_cond("resp_not_back_to_back", !prev_resp);
        check_cond("resp_expected", exp_resp.size() != 0);
        if (exp_resp.size() != 0) begin
          mon_line = exp_resp.pop_front();
          check("pmem_rdata", pmem_rdata, mon_line);
        end
        t_resp = $time;
      end
      if (arb_read && !prev_arb) begin
        check_cond("arb_read_expected", exp_arb.size() != 0);
        if (exp_arb.size() != 0) begin
          mon_e      = exp_arb.pop_front();
          cur_demand = mon_e.demand;
          check("arb_address", 256'(arb_address), 256'(mon_e.addr));
          // Prefetch launches with DONE and IDLE between it and the response.
          if (!mon_e.demand) begin
            check("prefetch_launch_gap", 256'($time - t_resp), 256'(3 * PERIOD));
          end
        end
      end else if (arb_read) begin
        check("arb_address_stable", 256'(arb_address), 256'(prev_addr));
      end
      if (arb_resp && arb_read) begin
        check("pmem_resp_with_arb_resp", 256'(pmem_resp), 256'(cur_demand));
        t_arb_resp = $time;
      end
      prev_resp = pmem_resp;
      prev_arb  = arb_read;
      prev_addr = arb_address;
    end
  end

  // mode 0: miss (arb_read next cycle), 1: buffer hit, 2: no latency check
  task automatic do_read(input logic [31:0] addr, input int mode);
    int   k;
    logic got;
    logic seen_arb;
    k = 0; got = 1'b0; seen_arb = 1'b0;
    @(posedge clk); #1;
    pmem_read    = 1'b1;
    pmem_address = addr;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (arb_read && !seen_arb) begin
        seen_arb = 1'b1;
        if (mode == 0) check("miss_arb_latency", 256'(k), 256'(2));
      end
      if (pmem_resp) got = 1'b1;
    end
    check_cond("read_completes", got);
    if (mode == 1) begin
      check("hit_resp_latency", 256'(k), 256'(2));
      check_cond("hit_without_arb_read", !seen_arb);
    end
    if (mode == 0) check_cond("miss_goes_to_arbiter", seen_arb);
    t_read_resp = $time;
    @(posedge clk); #1;
    pmem_read = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_arb.size() != 0 || arb_read) && k < 200);
    check_cond("drain_done", (exp_arb.size() == 0) && !arb_read);
  endtask

  task automatic do_read_pt(input logic [31:0] addr);
    int   k;
    int   late;
    logic got;
    logic seen;
    k = 0; late = 0; got = 1'b0; seen = 1'b0;
    @(posedge clk); #1;
    q_read = 1'b1;
    q_addr = addr;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (q_arb_read && !seen) begin
        seen = 1'b1;
        check("pt_arb_address", 256'(q_arb_addr), 256'({addr[31:5], 5'b0}));
      end
      if (q_resp) begin
        got = 1'b1;
        check("pt_rdata", q_rdata, line_of({addr[31:5], 5'b0}));
      end
    end
    check_cond("pt_read_completes", got);
    check_cond("pt_uses_arbiter", seen);
    @(posedge clk); #1;
    q_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (q_arb_read) late++;
    end
    check("pt_no_arb_after_resp", 256'(late), 256'(0));
  endtask

  initial begin
    int k;
    int resp_before;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pmem_resp",   256'(pmem_resp),   256'(0));
    check("rst_pmem_rdata",  pmem_rdata,        256'(0));
    check("rst_arb_read",    256'(arb_read),    256'(0));
    check("rst_arb_address", 256'(arb_address), 256'(0));
    check("rst_pt_arb_read", 256'(q_arb_read),  256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, then prefetch of the next line
    push_arb(32'h0000_1040, 1'b1);
    push_arb(32'h0000_1060, 1'b0);
    push_resp(32'h0000_1040);
    do_read(32'h0000_1040, 0);
    drain();

    // Sequential hit from the buffer, then prefetch of 0x1080
    push_resp(32'h0000_1060);
    push_arb(32'h0000_1080, 1'b0);
    do_read(32'h0000_1064, 1);
    drain();

    // Non-sequential miss; prefetch of 0x2020 replaces the buffered 0x1080
    push_arb(32'h0000_2000, 1'b1);
    push_arb(32'h0000_2020, 1'b0);
    push_resp(32'h0000_2000);
    do_read(32'h0000_2000, 0);
    drain();
    push_resp(32'h0000_2020);
    push_arb(32'h0000_2040, 1'b0);
    do_read(32'h0000_2020, 1);
    drain();
    push_arb(32'h0000_1080, 1'b1);
    push_arb(32'h0000_10A0, 1'b0);
    push_resp(32'h0000_1080);
    do_read(32'h0000_1080, 0);
    drain();

    // Request arriving while the prefetch of its line is outstanding
    push_arb(32'h0000_3000, 1'b1);
    push_arb(32'h0000_3020, 1'b0);
    push_resp(32'h0000_3000);
    do_read(32'h0000_3000, 0);
    k = 0;
    while (!arb_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_cond("prefetch_started", arb_read);
    push_resp(32'h0000_3020);
    push_arb(32'h0000_3040, 1'b0);
    do_read(32'h0000_3024, 2);
    check("req_during_prefetch_gap", 256'(t_read_resp - t_arb_resp), 256'(2 * PERIOD));
    drain();

    // Top line wraps to line 0
    push_arb(32'hFFFF_FFE0, 1'b1);
    push_arb(32'h0000_0000, 1'b0);
    push_resp(32'hFFFF_FFE0);
    do_read(32'hFFFF_FFEC, 0);
    drain();
    push_resp(32'h0000_0000);
    push_arb(32'h0000_0020, 1'b0);
    do_read(32'h0000_0008, 1);
    drain();

    // Asynchronous reset in the middle of a demand fetch
    push_arb(32'h0000_5000, 1'b1);
    @(posedge clk); #1;
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_5000;
    k = 0;
    while (!arb_read && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_cond("demand_started", arb_read);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_arb_read",    256'(arb_read),    256'(0));
    check("rst_async_arb_address", 256'(arb_address), 256'(0));
    check("rst_async_pmem_resp",   256'(pmem_resp),   256'(0));
    pmem_read = 1'b0;
    resp_before = n_resp;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_resp_after_reset", 256'(n_resp), 256'(resp_before));
    // Line 0x20 was buffered before reset; it must now miss
    push_arb(32'h0000_0020, 1'b1);
    push_arb(32'h0000_0040, 1'b0);
    push_resp(32'h0000_0020);
    do_read(32'h0000_0020, 0);
    drain();
    check("resp_queue_empty", 256'(exp_resp.size()), 256'(0));

    // Pass-through instance: every read goes to the arbiter, nothing follows
    do_read_pt(32'h0000_1040);
    do_read_pt(32'h0000_1064);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
